// File: rtl/ihex_loader.sv
// Streaming Intel HEX parser: ASCII download bytes in, byte-lane writes to a word-organised program memory out.
// It verifies checksums, tracks the extended segment/linear base, latches the first error and detects EOF.
module ihex_loader #(
    parameter int  ADDR_W      = 15,
    parameter int  LANE_W      = 1,
    parameter bit  SUPPORT_EXT = 1'b1,
    localparam int LW          = (LANE_W > 0) ? LANE_W : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dl_active,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    output logic                     wr_en,
    output logic [ADDR_W-LANE_W-1:0] wr_addr,
    output logic [LW-1:0]            wr_lane,
    output logic [7:0]               wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [15:0]              rec_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_ADR0, S_ADR1, S_ADR2, S_ADR3,
        S_TYP_H, S_TYP_L, S_DAT_H, S_DAT_L, S_CHK_H, S_CHK_L, S_DONE
    } state_t;

    localparam logic [1:0] E_FORMAT = 2'd1;
    localparam logic [1:0] E_CHKSUM = 2'd2;
    localparam logic [1:0] E_RANGE  = 2'd3;

    state_t                  r_state;
    logic                    r_dl_q;
    logic [3:0]              r_nib;
    logic [7:0]              r_sum;
    logic [7:0]              r_len;
    logic [7:0]              r_type;
    logic [7:0]              r_cnt;
    logic [15:0]             r_off;
    logic [15:0]             r_data16;
    logic [31:0]             r_base;
    logic                    r_wr_en;
    logic [ADDR_W-LANE_W-1:0] r_wr_addr;
    logic [LW-1:0]           r_wr_lane;
    logic [7:0]              r_wr_data;
    logic                    r_done;
    logic                    r_err;
    logic [1:0]              r_err_code;
    logic [15:0]             r_rec;

    logic [4:0]              w_dec;
    logic                    w_hex_ok;
    logic [3:0]              w_nib;
    logic [7:0]              w_byte;
    logic [7:0]              w_sum_nx;
    logic [31:0]             w_eff;
    logic                    w_in_range;

    // Returns {valid, nibble}; letters use the low ASCII nibble plus 9 for both cases.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

    function automatic logic is_ext(input logic [7:0] t);
        return SUPPORT_EXT && (t == 8'h02 || t == 8'h04);
    endfunction

    assign w_dec      = hex_decode(in_byte);
    assign w_hex_ok   = w_dec[4];
    assign w_nib      = w_dec[3:0];
    assign w_byte     = {r_nib, w_nib};
    assign w_sum_nx   = r_sum + w_byte;
    assign w_eff      = r_base + {16'd0, r_off};
    assign w_in_range = (w_eff >> ADDR_W) == 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dl_q     <= 1'b0;
            r_base     <= 32'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_lane  <= '0;
            r_wr_data  <= 8'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_rec      <= 16'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_dl_q  <= dl_active;
            if (!dl_active) begin
                r_state <= S_IDLE;
            end else if (!r_dl_q) begin
                r_state    <= S_IDLE;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
                r_rec      <= 16'd0;
                r_base     <= 32'd0;
            end else if (in_valid) begin
                if (r_state == S_IDLE) begin
                    if (in_byte == 8'h3A) begin
                        r_sum   <= 8'd0;
                        r_state <= S_LEN_H;
                    end
                end else if (r_state != S_DONE && !w_hex_ok) begin
                    if (!r_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= E_FORMAT;
                    end
                    r_state <= S_IDLE;
                end else begin
                    r_nib <= w_nib;
                    case (r_state)
                        S_LEN_H: r_state <= S_LEN_L;
                        S_LEN_L: begin
                            r_len   <= w_byte;
                            r_sum   <= w_sum_nx;
                            r_state <= S_ADR0;
                        end
                        S_ADR0: begin
                            r_off   <= {r_off[11:0], w_nib};
                            r_state <= S_ADR1;
                        end
                        S_ADR1: begin
                            r_off   <= {r_off[11:0], w_nib};
                            r_sum   <= w_sum_nx;
                            r_state <= S_ADR2;
                        end
                        S_ADR2: begin
                            r_off   <= {r_off[11:0], w_nib};
                            r_state <= S_ADR3;
                        end
                        S_ADR3: begin
                            r_off   <= {r_off[11:0], w_nib};
                            r_sum   <= w_sum_nx;
                            r_state <= S_TYP_H;
                        end
                        S_TYP_H: r_state <= S_TYP_L;
                        S_TYP_L: begin
                            r_type <= w_byte;
                            r_sum  <= w_sum_nx;
                            r_cnt  <= r_len;
                            // Base-address records must carry exactly one 16-bit word.
                            if (is_ext(w_byte) && r_len != 8'd2) begin
                                if (!r_err) begin
                                    r_err      <= 1'b1;
                                    r_err_code <= E_FORMAT;
                                end
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= (r_len == 8'd0) ? S_CHK_H : S_DAT_H;
                            end
                        end
                        S_DAT_H: r_state <= S_DAT_L;
                        S_DAT_L: begin
                            r_sum    <= w_sum_nx;
                            r_data16 <= {r_data16[7:0], w_byte};
                            r_off    <= r_off + 16'd1;
                            r_cnt    <= r_cnt - 8'd1;
                            if (r_type == 8'h00) begin
                                if (w_in_range) begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= w_eff[ADDR_W-1:LANE_W];
                                    r_wr_lane <= (LANE_W == 0) ? '0 : w_eff[LW-1:0];
                                    r_wr_data <= w_byte;
                                end else if (!r_err) begin
                                    r_err      <= 1'b1;
                                    r_err_code <= E_RANGE;
                                end
                            end
                            r_state <= (r_cnt == 8'd1) ? S_CHK_H : S_DAT_H;
                        end
                        S_CHK_H: r_state <= S_CHK_L;
                        S_CHK_L: begin
                            r_state <= S_IDLE;
                            if (w_sum_nx == 8'd0) begin
                                if (r_rec != 16'hFFFF)
                                    r_rec <= r_rec + 16'd1;
                                if (r_type == 8'h01) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else if (is_ext(r_type)) begin
                                    r_base <= (r_type == 8'h02) ? {12'd0, r_data16, 4'd0}
                                                                : {r_data16, 16'd0};
                                end
                            end else if (!r_err) begin
                                r_err      <= 1'b1;
                                r_err_code <= E_CHKSUM;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_lane   = r_wr_lane;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign rec_count = r_rec;
endmodule

// File: tb/tb_ihex_loader.sv
// Bench for ihex_loader: two instances (14-bit and 16-bit word address) share one ASCII stream and are
// compared against an address-arithmetic model of the record rules.
module tb_ihex_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, dl_active, in_valid;
    logic [7:0]  in_byte;

    logic        a_wr_en, a_busy, a_done, a_err;
    logic [13:0] a_wr_addr;
    logic [0:0]  a_wr_lane;
    logic [7:0]  a_wr_data;
    logic [1:0]  a_err_code;
    logic [15:0] a_rec;
    logic        b_wr_en, b_busy, b_done, b_err;
    logic [15:0] b_wr_addr;
    logic [0:0]  b_wr_lane;
    logic [7:0]  b_wr_data;
    logic [1:0]  b_err_code;
    logic [15:0] b_rec;

    ihex_loader #(.ADDR_W(15), .LANE_W(1), .SUPPORT_EXT(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .dl_active(dl_active), .in_valid(in_valid), .in_byte(in_byte),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_lane(a_wr_lane), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .err(a_err), .err_code(a_err_code), .rec_count(a_rec));
    ihex_loader #(.ADDR_W(17), .LANE_W(1), .SUPPORT_EXT(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .dl_active(dl_active), .in_valid(in_valid), .in_byte(in_byte),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_lane(b_wr_lane), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code), .rec_count(b_rec));

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    logic [7:0]  rec_dat[256];

    logic [31:0] m_base[2];
    bit          m_err[2];
    logic [1:0]  m_code[2];
    int          m_cnt[2];
    bit          m_done[2];
    int          aw[2] = '{15, 17};

    always @(negedge clk) begin
        if (a_wr_en) got_a.push_back({16'(a_wr_addr), 8'(a_wr_lane), a_wr_data});
        if (b_wr_en) got_b.push_back({16'(b_wr_addr), 8'(b_wr_lane), b_wr_data});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        in_valid = 1'b1;
        in_byte  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input int lcm);
        bit lc;
        lc = (lcm == 2) ? bit'($urandom_range(0, 1)) : (lcm == 1);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (lc ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
    endfunction

    task automatic send_hex(input logic [7:0] b, input int lcm);
        send_char(hexc(b[7:4], lcm));
        send_char(hexc(b[3:0], lcm));
    endtask

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            m_base[w] = 32'd0; m_err[w] = 1'b0; m_code[w] = 2'd0; m_cnt[w] = 0; m_done[w] = 1'b0;
        end
    endtask

    task automatic set_err(input int w, input logic [1:0] code);
        if (!m_err[w]) begin
            m_err[w]  = 1'b1;
            m_code[w] = code;
        end
    endtask

    // Effect of one record on each target, from the addressing and checksum rules.
    task automatic model_record(input logic [7:0] typ, input logic [15:0] off, input int len,
                                input bit good, input int bad_pos);
        logic [31:0] eff;
        logic [15:0] d16;
        int          nbytes;
        for (int w = 0; w < 2; w++) begin
            if (m_done[w]) continue;
            if ((typ == 8'h02 || typ == 8'h04) && len != 2) begin
                set_err(w, 2'd1);
                continue;
            end
            nbytes = (bad_pos < 0) ? len : bad_pos / 2;
            for (int i = 0; i < nbytes; i++) begin
                if (typ != 8'h00) continue;
                eff = m_base[w] + ((32'(off) + 32'(i)) % 32'h10000);
                if (eff < (32'd1 << aw[w])) begin
                    if (w == 0) exp_a.push_back({16'(eff >> 1), 8'(eff % 2), rec_dat[i]});
                    else        exp_b.push_back({16'(eff >> 1), 8'(eff % 2), rec_dat[i]});
                end else begin
                    set_err(w, 2'd3);
                end
            end
            if (bad_pos >= 0) begin
                set_err(w, 2'd1);
                continue;
            end
            if (!good) begin
                set_err(w, 2'd2);
                continue;
            end
            if (m_cnt[w] < 65535) m_cnt[w]++;
            d16 = {rec_dat[0], rec_dat[1]};
            if (typ == 8'h01) m_done[w] = 1'b1;
            if (typ == 8'h02) m_base[w] = 32'(d16) * 16;
            if (typ == 8'h04) m_base[w] = 32'(d16) * 65536;
        end
    endtask

    task automatic send_record(input logic [7:0] typ, input logic [15:0] off, input int len,
                               input logic [7:0] chk_xor, input int bad_pos, input int lcm);
        logic [7:0] sum;
        bit         aborted;
        sum = 8'(len) + off[15:8] + off[7:0] + typ;
        for (int i = 0; i < len; i++) sum += rec_dat[i];
        aborted = 1'b0;
        send_char(8'h3A);
        send_hex(8'(len), lcm);
        send_hex(off[15:8], lcm);
        send_hex(off[7:0], lcm);
        send_hex(typ, lcm);
        for (int i = 0; i < len && !aborted; i++) begin
            if (bad_pos == 2 * i) begin
                send_char(8'h47);
                aborted = 1'b1;
            end else if (bad_pos == 2 * i + 1) begin
                send_char(hexc(rec_dat[i][7:4], lcm));
                send_char(8'h47);
                aborted = 1'b1;
            end else begin
                send_hex(rec_dat[i], lcm);
            end
        end
        if (!aborted) send_hex((8'h00 - sum) ^ chk_xor, lcm);
        model_record(typ, off, len, chk_xor == 8'h00, bad_pos);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] g[$], e[$];
        string       t;
        for (int w = 0; w < 2; w++) begin
            t = {tag, (w == 0) ? "/a15" : "/b17"};
            check({t, " done"},  (w == 0) ? a_done : b_done, m_done[w]);
            check({t, " err"},   (w == 0) ? a_err : b_err, m_err[w]);
            check({t, " code"},  (w == 0) ? a_err_code : b_err_code, m_code[w]);
            check({t, " count"}, (w == 0) ? a_rec : b_rec, m_cnt[w]);
            check({t, " busy"},  (w == 0) ? a_busy : b_busy, 1'b0);
            if (w == 0) begin g = got_a; e = exp_a; end
            else        begin g = got_b; e = exp_b; end
            check({t, " nwr"}, g.size(), e.size());
            for (int i = 0; i < g.size() && i < e.size(); i++)
                check($sformatf("%s wr%0d", t, i), g[i], e[i]);
        end
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, " wr_en"},   {a_wr_en, b_wr_en}, 2'b00);
        check({tag, " wr_addr"}, {a_wr_addr, b_wr_addr}, 30'd0);
        check({tag, " wr_lane"}, {a_wr_lane, b_wr_lane}, 2'd0);
        check({tag, " wr_data"}, {a_wr_data, b_wr_data}, 16'd0);
        check({tag, " busy"},    {a_busy, b_busy}, 2'b00);
        check({tag, " done"},    {a_done, b_done}, 2'b00);
        check({tag, " err"},     {a_err, b_err, a_err_code, b_err_code}, 6'd0);
        check({tag, " count"},   {a_rec, b_rec}, 32'd0);
    endtask

    task automatic new_session();
        dl_active = 1'b0;
        tick(2);
        dl_active = 1'b1;
        tick(2);
        model_clear();
    endtask

    task automatic load_1234();
        rec_dat[0] = 8'h12; rec_dat[1] = 8'h34; rec_dat[2] = 8'h56; rec_dat[3] = 8'h78;
    endtask

    logic [31:0] tp[4];
    logic [7:0]  typ;
    logic [15:0] off;
    int          len, k, nsep;

    initial begin
        rst_n = 1'b0; dl_active = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        model_clear();
        tick(3);
        check_reset("reset");
        rst_n = 1'b1;
        dl_active = 1'b1;
        tick(3);

        // Plain data record, uppercase
        load_1234();
        send_record(8'h00, 16'h0010, 4, 8'h00, -1, 0);
        tick(3);
        tp = '{{16'h008, 8'd0, 8'h12}, {16'h008, 8'd1, 8'h34},
               {16'h008 + 16'd1, 8'd0, 8'h56}, {16'h009, 8'd1, 8'h78}};
        for (int i = 0; i < 4; i++)
            check($sformatf("first rec wr%0d", i), (i < got_a.size()) ? got_a[i] : 32'hDEADBEEF, tp[i]);
        check_all("data upper");

        // Lowercase with CRLF, then EOF, then ignored trailing record
        send_char(8'h0D); send_char(8'h0A);
        send_record(8'h00, 16'h0010, 4, 8'h00, -1, 1);
        send_char(8'h0D); send_char(8'h0A);
        send_record(8'h01, 16'h0000, 0, 8'h00, -1, 0);
        tick(3);
        check_all("eof");
        send_record(8'h00, 16'h0020, 4, 8'h00, -1, 0);
        tick(3);
        check_all("after done");

        // Bad checksum still writes
        new_session();
        check_all("session clear");
        send_record(8'h00, 16'h0010, 4, 8'h01, -1, 0);
        tick(3);
        check_all("bad chk");

        // Extended linear base 0x10000 then data at offset 0
        new_session();
        rec_dat[0] = 8'h00; rec_dat[1] = 8'h01;
        send_record(8'h04, 16'h0000, 2, 8'h00, -1, 0);
        rec_dat[0] = 8'hAA; rec_dat[1] = 8'hBB;
        send_record(8'h00, 16'h0000, 2, 8'h00, -1, 0);
        tick(3);
        check("ext b17 wr0", (got_b.size() > 0) ? got_b[0] : 32'hDEADBEEF, {16'h8000, 8'd0, 8'hAA});
        check_all("ext linear");

        // Non-hex third data character
        new_session();
        load_1234();
        send_record(8'h00, 16'h0010, 4, 8'h00, 2, 0);
        send_record(8'h00, 16'h0040, 4, 8'h00, -1, 0);
        tick(3);
        check_all("bad char");

        // dl_active dropped mid-record; char in the falling cycle is ignored
        send_str(":040010001");
        check("mid busy", {a_busy, b_busy}, 2'b11);
        dl_active = 1'b0;
        send_char(8'h32);
        tick(2);
        check_all("dl drop");
        send_str(":00000001FF");
        tick(2);
        check_all("dl low ignore");
        dl_active = 1'b1;
        tick(2);
        model_clear();
        check_all("dl rise");
        send_record(8'h00, 16'h0010, 4, 8'h00, -1, 2);
        tick(3);
        check_all("after rise");

        // Reset mid-record
        send_str(":04001000");
        rst_n = 1'b0;
        tick(1);
        check_reset("mid reset");
        rst_n = 1'b1;
        model_clear();
        tick(3);
        send_record(8'h00, 16'h0100, 4, 8'h00, -1, 0);
        tick(3);
        check_all("after reset");

        // Randomized record mix
        new_session();
        for (int r = 0; r < 40; r++) begin
            k = $urandom_range(0, 9);
            len = $urandom_range(0, 6);
            off = 16'($urandom_range(0, 16'h7FFF));
            typ = 8'h00;
            for (int i = 0; i < 8; i++) rec_dat[i] = 8'($urandom);
            if (k == 0) off = 16'hFFFE;
            if (k == 6) begin typ = 8'h04; len = 2; rec_dat[0] = 8'h00; rec_dat[1] = 8'($urandom_range(0, 2)); end
            if (k == 7) begin typ = 8'h02; len = 2; rec_dat[0] = 8'($urandom_range(0, 8'h1F)); end
            if (k == 8) typ = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h05;
            if (k == 9) begin typ = 8'h04; len = 1; end
            nsep = $urandom_range(0, 2);
            for (int s = 0; s < nsep; s++) send_char(($urandom_range(0, 1) == 0) ? 8'h0A : 8'h20);
            send_record(typ, off, len, ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00, -1, 2);
            tick(2);
            check_all($sformatf("rand%0d", r));
        end
        send_record(8'h01, 16'h0000, 0, 8'h00, -1, 0);
        tick(3);
        check_all("rand eof");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
